// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and stall-controller state.
// Imported by the pipeline control blocks.
package cpu_types_pkg;

    localparam int REG_BITS = 5;

    typedef logic [REG_BITS-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detect: the load in EX feeds a source of the ID instruction.
// Register 0 is hardwired zero, so it never creates a hazard.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             idex_memToReg,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    output logic             load_use
);

    logic rt_nz;
    logic match;

    assign rt_nz    = |idex_rt;
    assign match    = (idex_rt == ifid_rs) | (idex_rt == ifid_rt);
    assign load_use = idex_memToReg & rt_nz & match;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline (Mealy outputs, RUN/MEM_WAIT/HALTED).
// Define PIPE_PERF_CNT_EN to add the stall_cnt/flush_cnt performance counters.
module pipeline_stall_ctrl
    import cpu_types_pkg::*;
#(
    parameter int REG_W = 5
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             exmem_redirect,
    input  logic             idex_memToReg,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             memwb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt_out
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    pipe_state_t state;
    pipe_state_t state_nxt;

    logic load_use;
    logic mem_busy;
    logic halt_set;
    logic redir;

    logic pc_en_c;
    logic ifid_en_c;
    logic idex_en_c;
    logic exmem_en_c;
    logic memwb_en_c;
    logic ifid_fl_c;
    logic idex_fl_c;
    logic exmem_fl_c;

    hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard (
        .idex_memToReg(idex_memToReg),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .load_use     (load_use)
    );

    assign mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= RUN;
            halt_out <= 1'b0;
        end else begin
            state <= state_nxt;
            if (halt_set)
                halt_out <= 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        halt_set   = 1'b0;
        redir      = 1'b0;
        pc_en_c    = 1'b0;
        ifid_en_c  = 1'b0;
        idex_en_c  = 1'b0;
        exmem_en_c = 1'b0;
        memwb_en_c = 1'b0;
        ifid_fl_c  = 1'b0;
        idex_fl_c  = 1'b0;
        exmem_fl_c = 1'b0;
        case (state)
            RUN, MEM_WAIT: begin
                if (memwb_halt) begin
                    state_nxt = HALTED;
                    halt_set  = 1'b1;
                end else if (mem_busy) begin
                    state_nxt = MEM_WAIT;
                end else begin
                    state_nxt  = RUN;
                    idex_en_c  = 1'b1;
                    exmem_en_c = 1'b1;
                    memwb_en_c = 1'b1;
                    // Redirect squashes wrong-path work, so it beats load-use and ~ihit.
                    if (exmem_redirect) begin
                        redir      = 1'b1;
                        pc_en_c    = 1'b1;
                        ifid_en_c  = 1'b1;
                        ifid_fl_c  = 1'b1;
                        idex_fl_c  = 1'b1;
                        exmem_fl_c = 1'b1;
                    end else if (load_use) begin
                        idex_fl_c = 1'b1;
                    end else if (!ihit) begin
                        ifid_en_c = 1'b1;
                        ifid_fl_c = 1'b1;
                    end else begin
                        pc_en_c   = 1'b1;
                        ifid_en_c = 1'b1;
                    end
                end
            end
            default: state_nxt = HALTED;
        endcase
    end

    // Keep every register frozen while reset is held.
    assign pc_en       = pc_en_c    & n_rst;
    assign ifid_en     = ifid_en_c  & n_rst;
    assign idex_en     = idex_en_c  & n_rst;
    assign exmem_en    = exmem_en_c & n_rst;
    assign memwb_en    = memwb_en_c & n_rst;
    assign ifid_flush  = ifid_fl_c  & n_rst;
    assign idex_flush  = idex_fl_c  & n_rst;
    assign exmem_flush = exmem_fl_c & n_rst;

`ifdef PIPE_PERF_CNT_EN
    logic stall_inc;

    assign stall_inc = ~pc_en_c & (state != HALTED);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (redir && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed pins plus random stimulus
// checked each cycle against a rule-level model of the controller.
module tb_pipeline_stall_ctrl;

    localparam int REG_W = 5;

    logic clk = 1'b0;
    logic n_rst;
    logic ihit;
    logic dhit;
    logic exmem_dREN;
    logic exmem_dWEN;
    logic exmem_redirect;
    logic idex_memToReg;
    logic [REG_W-1:0] idex_rt;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic memwb_halt;
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic halt_out;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit running = 1'b1;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .REG_W(REG_W)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .ihit          (ihit),
        .dhit          (dhit),
        .exmem_dREN    (exmem_dREN),
        .exmem_dWEN    (exmem_dWEN),
        .exmem_redirect(exmem_redirect),
        .idex_memToReg (idex_memToReg),
        .idex_rt       (idex_rt),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .memwb_halt    (memwb_halt),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .idex_en       (idex_en),
        .exmem_en      (exmem_en),
        .memwb_en      (memwb_en),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .exmem_flush   (exmem_flush),
        .halt_out      (halt_out)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    // Output vector order: pc,ifid,idex,exmem,memwb enables; ifid,idex,exmem flushes; halt.
    logic [8:0] dut_vec;
    logic [8:0] exp_vec;
    bit m_halted;
    int unsigned m_stall;
    int unsigned m_flush;

    assign dut_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, exmem_flush, halt_out};

    function automatic logic [8:0] model(
        input bit rst_ok, input bit halted);
        bit busy, lu, go, rd, lus, bub;
        bit pc, ife, ifl, idfl;
        busy = (exmem_dREN || exmem_dWEN) && !dhit;
        lu   = idex_memToReg && idex_rt != 0 &&
               (idex_rt == ifid_rs || idex_rt == ifid_rt);
        if (!rst_ok) return 9'b0;
        if (halted) return 9'b0_0000_0001;
        go   = !memwb_halt && !busy;
        rd   = go && exmem_redirect;
        lus  = go && !exmem_redirect && lu;
        bub  = go && !exmem_redirect && !lu && !ihit;
        pc   = rd || (go && !lu && ihit);
        ife  = go && (rd || !lu);
        ifl  = rd || bub;
        idfl = rd || lus;
        return {pc, ife, go, go, go, ifl, idfl, rd, 1'b0};
    endfunction

    assign exp_vec = model(n_rst, m_halted);

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_halted <= 1'b0;
            m_stall  <= 0;
            m_flush  <= 0;
        end else if (!m_halted) begin
            if (!exp_vec[8] && m_stall != 32'hffff_ffff)
                m_stall <= m_stall + 1;
            if (exp_vec[1] && m_flush != 32'hffff_ffff)
                m_flush <= m_flush + 1;
            if (memwb_halt)
                m_halted <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (running) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t: dut=%b exp=%b", $time, dut_vec, exp_vec);
            end
`ifdef PIPE_PERF_CNT_EN
            checks++;
            if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
                errors++;
                $display("FAIL counters t=%0t: dut=%0d/%0d exp=%0d/%0d",
                         $time, stall_cnt, flush_cnt, m_stall, m_flush);
            end
`endif
        end
    end

    task automatic pin(input string nm, input logic [8:0] lit);
        checks++;
        if (dut_vec !== lit) begin
            errors++;
            $display("FAIL %s: dut=%b exp=%b", nm, dut_vec, lit);
        end
        checks++;
        if (exp_vec !== lit) begin
            errors++;
            $display("FAIL %s_model: model=%b exp=%b", nm, exp_vec, lit);
        end
    endtask

    task automatic idle();
        ihit = 1; dhit = 0; exmem_dREN = 0; exmem_dWEN = 0;
        exmem_redirect = 0; idex_memToReg = 0;
        idex_rt = 0; ifid_rs = 0; ifid_rt = 0; memwb_halt = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    localparam logic [8:0] ALL_ON = 9'b11111_000_0;
    localparam logic [8:0] ALL_OFF = 9'b00000_000_0;

    initial begin
        n_rst = 0;
        idle();
        @(negedge clk);
        pin("reset_hold", ALL_OFF);
        next();
        n_rst = 1;
        @(negedge clk);
        pin("idle", ALL_ON);

        next();
        exmem_dREN = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pin("mem_wait", ALL_OFF);
            next();
        end
        dhit = 1;
        @(negedge clk);
        pin("mem_done", ALL_ON);

        next();
        idle();
        idex_memToReg = 1; idex_rt = 5; ifid_rs = 5;
        @(negedge clk);
        pin("load_use", 9'b00111_010_0);
        next();
        idex_rt = 0; ifid_rs = 0;
        @(negedge clk);
        pin("load_r0", ALL_ON);

        next();
        idex_rt = 7; ifid_rt = 7; ihit = 0; exmem_redirect = 1;
        @(negedge clk);
        pin("redirect", 9'b11111_111_0);

        next();
        idle();
        ihit = 0;
        @(negedge clk);
        pin("imiss", 9'b01111_100_0);
        next();
        idex_memToReg = 1; idex_rt = 3; ifid_rt = 3;
        @(negedge clk);
        pin("lu_imiss", 9'b00111_010_0);

        next();
        idle();
        exmem_dWEN = 1;
        @(negedge clk);
        pin("pre_rst_wait", ALL_OFF);
        next();
        n_rst = 0;
        @(negedge clk);
        pin("rst_in_wait", ALL_OFF);
        next();
        n_rst = 1;
        idle();
        @(negedge clk);
        pin("after_rst", ALL_ON);

        next();
        memwb_halt = 1;
        @(negedge clk);
        pin("halt_edge", ALL_OFF);
        next();
        memwb_halt = 0;
        @(negedge clk);
        pin("halted", 9'b00000_000_1);
        next();
        exmem_redirect = 1;
        @(negedge clk);
        pin("halted_sticky", 9'b00000_000_1);
        next();
        n_rst = 0;
        idle();
        @(negedge clk);
        pin("halt_reset", ALL_OFF);

        for (int i = 0; i < 3000; i++) begin
            next();
            n_rst = !(($urandom_range(0, 99) == 0) ||
                      (m_halted && $urandom_range(0, 3) == 0));
            ihit           = $urandom_range(0, 3) != 0;
            dhit           = $urandom_range(0, 1);
            exmem_dREN     = $urandom_range(0, 3) == 0;
            exmem_dWEN     = $urandom_range(0, 5) == 0;
            exmem_redirect = $urandom_range(0, 5) == 0;
            idex_memToReg  = $urandom_range(0, 1);
            idex_rt        = REG_W'($urandom_range(0, 3));
            ifid_rs        = REG_W'($urandom_range(0, 3));
            ifid_rt        = REG_W'($urandom_range(0, 3));
            memwb_halt     = $urandom_range(0, 79) == 0;
        end
        @(negedge clk);
        running = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Each cycle it decides which pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC may load, and which inject a bubble.
- Inputs are cache hit signals, load-use hazard, branch/jump resolution and halt.
- Sits beside the datapath; drives the per-register enable inputs and flush inputs of every pipeline register.

Parameters:
- REG_W, 5, register-index width for hazard compares.
- CNT_W, 32, width of performance counters (used only with PIPE_PERF_CNT_EN).

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- ihit  in  1  icache hit; fetched instruction valid this cycle
- dhit  in  1  dcache hit; MEM-stage access completes this cycle
- exmem_dREN  in  1  load in MEM stage
- exmem_dWEN  in  1  store in MEM stage
- exmem_redirect  in  1  taken branch/jump resolved in MEM stage
- idex_memToReg  in  1  instruction in EX is a load
- idex_rt  in  REG_W  load destination in EX
- ifid_rs  in  REG_W  source register of instruction in ID
- ifid_rt  in  REG_W  second source of instruction in ID
- memwb_halt  in  1  halt has reached WB
- pc_en  out  1  PC load enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous clear; takes effect only when the matching enable is 1
- halt_out  out  1  registered, sticky halt to system
- stall_cnt, flush_cnt  out  CNT_W each  performance counters (feature only)

Behaviour:
- Reset: state=RUN, halt_out=0, counters=0. While n_rst=0 all enables and flushes are 0. A reset mid-stall returns to RUN with no pending wait.
- States: RUN, MEM_WAIT, HALTED. Outputs are Mealy (state plus current inputs); state and halt_out are registered.
- mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit.
- load_use = idex_memToReg & (idex_rt != 0) & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt)).
- Priority in RUN and MEM_WAIT; first match wins:
  1. memwb_halt: all enables 0, no flushes; next=HALTED; halt_out<=1.
  2. mem_busy: freeze; all enables and pc_en 0; next=MEM_WAIT.
  3. exmem_redirect: all enables 1, pc_en 1; ifid_flush, idex_flush and exmem_flush = 1. This overrides load_use and ~ihit (wrong-path work is squashed).
  4. load_use: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1 (bubble), exmem_en=memwb_en=1.
  5. ~ihit: pc_en=0, ifid_en=1 with ifid_flush=1 (bubble), rest advance.
  6. Otherwise all enables 1, no flushes.
- MEM_WAIT exits to RUN in the first cycle where mem_busy=0. In that cycle rules 3-6 apply normally.
- HALTED is terminal until reset: all enables 0, halt_out=1. memwb_halt remains visible because memwb_en=0.
- Simultaneous load_use and ~ihit: rule 4 only; IF/ID holds.
- Flush asserted with enable=0 is never produced.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: stall_cnt increments in each cycle with pc_en=0 outside HALTED. flush_cnt increments once per redirect cycle. Both saturate at all-ones and reset to 0.
- Undefined: ports absent, no counter logic.

Decomposition:
- pipe_state_t enum {RUN, MEM_WAIT, HALTED} goes in cpu_types_pkg; the existing regbits_t is used for register indices.
- One natural combinational sub-module, hazard_detect, computes load_use from the EX/ID fields.
- The FSM and priority encoder stay in pipeline_stall_ctrl.

Test Plan:
- Reset mid-MEM_WAIT (n_rst pulse while exmem_dREN=1, dhit=0) -> state RUN, halt_out=0, all enables 0 during reset, 1 in the first idle cycle after release.
- exmem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> enables 0 for 3 cycles, all 1 on the 4th, state back to RUN.
- idex_memToReg=1, idex_rt=5, ifid_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. Repeat with idex_rt=0 -> no stall.
- exmem_redirect=1 together with load_use=1 and ihit=0 -> pc_en=1 and all three flushes 1.
- ihit=0, no other event -> pc_en=0, ifid_flush=1, idex_en=exmem_en=memwb_en=1.
- memwb_halt=1 -> next cycle halt_out=1, all enables 0. Stays there after memwb_halt drops, until reset.
